screen_sequencer: RTL
=====================

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 Parameter: NUM_REQ, default 3, number of sprite-drawer requesters sharing the VGA write port during gameplay.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 start_key  input  1  level, player start request.
REQ-005 game_over  input  1  level, game logic signals end of game.
REQ-006 fill_done  input  1  full-screen fill engine finished pixel 76799.
REQ-007 fill_x / fill_y / fill_colour  input  9 / 8 / 3  fill engine pixel outputs.
REQ-008 fill_plot  output  1  advance fill engine.
REQ-009 display_title / display_end  output  1 / 1  fill engine image select, one-hot or both 0.
REQ-010 req  input  NUM_REQ  per-requester write request, level, held for a burst.
REQ-011 req_x / req_y / req_colour  input  9*NUM_REQ / 8*NUM_REQ / 3*NUM_REQ  packed requester pixels; requester i occupies slice i.
REQ-012 grant  output  NUM_REQ  one-hot (or zero) grant.
REQ-013 vga_x / vga_y / vga_colour / vga_plot  output  9 / 8 / 3 / 1  VGA adapter write port.
REQ-014 state  output  3  current FSM state encoding, for debug/LEDs.

Function
REQ-015 FSM states: TITLE_DRAW, TITLE_WAIT, GAME, END_DRAW, END_WAIT.
REQ-016 TITLE_DRAW: fill_plot=1, display_title=1; on fill_done go TITLE_WAIT.
REQ-017 TITLE_WAIT: fill_plot=0; on start_key go GAME.
REQ-018 GAME: arbitration active; on game_over go END_DRAW; start_key ignored.
REQ-019 END_DRAW: fill_plot=1, display_end=1; on fill_done go END_WAIT.
REQ-020 END_WAIT: on start_key go TITLE_DRAW.
REQ-021 fill_done outside a DRAW state is ignored.
REQ-022 In DRAW states, vga_x/y/colour register fill_x/y/fill_colour each cycle, and vga_plot registers fill_plot delayed one cycle (fill engine colour has 1-cycle ROM latency).
REQ-023 On DRAW exit, vga_plot deasserts on the following cycle; no pixel is written in WAIT states.
REQ-024 Arbitration is round-robin with burst lock: grant stays on requester i while req[i]=1 and state is GAME.
REQ-025 When the holder drops req or no grant exists, the next grant goes to the first requester with req=1, searching from last_holder+1 with wrap at NUM_REQ-1->0; after reset, last_holder=NUM_REQ-1, so requester 0 has priority.
REQ-026 A grant change takes one cycle: grant updates on the edge after req changes.
REQ-027 In GAME, vga_x/y/colour/plot register the granted requester's slice and req bit; with no grant, vga_plot=0.
REQ-028 When game_over is asserted during a burst, grant is cleared on the same edge that enters END_DRAW, and no requester pixel is written after that edge.
REQ-029 grant is 0 in every state except GAME.
REQ-030 Simultaneous game_over and start_key in GAME: game_over wins.

Reset
REQ-031 Asynchronous reset (resetn=0) SHALL force: state=TITLE_DRAW, grant=0, last_holder=NUM_REQ-1, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0.
REQ-032 The registered DRAW-state outputs SHALL be 0 during reset; fill_plot and display_title SHALL assert on the first cycle after reset release.
REQ-033 Reset mid-fill or mid-burst SHALL abandon the operation without flagging an error; the fill engine restarts from its own reset.

Structure
REQ-034 A shared package SHALL hold the state enum, screen constants (320, 240, 76800) and the coordinate/colour widths 9/8/3.
REQ-035 One sub-module, rr_arbiter (parameter NUM_REQ; in: req, enable; out: grant), SHALL implement REQ-024..026; the FSM and write-port mux SHALL stay in screen_sequencer.

Verification
REQ-036 Reset release, fill_done pulse after 76800 cycles -> display_title=1 throughout, then state=TITLE_WAIT, vga_plot=0 one cycle after fill_done.
REQ-037 In TITLE_WAIT, pulse start_key -> state=GAME next cycle, grant=0 with req=000.
REQ-038 In GAME, assert req=111 for 3 cycles, then drop req[0] -> grant=001, then 010; after dropping req[1], grant=100; after re-raising req[0] and dropping req[2], grant=001 (wrap).
REQ-039 Requester 1 bursting (x=5, y=7, colour=3'b110) -> vga_x=5, vga_y=7, vga_colour=110, vga_plot=1 one cycle after grant=010.
REQ-040 During burst, assert game_over and start_key together -> next cycle state=END_DRAW, grant=000, display_end=1, fill_plot=1.
REQ-041 Assert resetn=0 asynchronously mid-END_DRAW -> outputs zeroed immediately without a clock edge; state=TITLE_DRAW.

Source files
------------

// File: rtl/screen_sequencer_pkg.sv
// Shared types and constants for the screen sequencer and its arbiter.
package screen_sequencer_pkg;

  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int C_W = 3;

  localparam int SCREEN_W      = 320;
  localparam int SCREEN_H      = 240;
  localparam int SCREEN_PIXELS = SCREEN_W * SCREEN_H;  // 76800

  typedef enum logic [2:0] {
    TITLE_DRAW = 3'd0,
    TITLE_WAIT = 3'd1,
    GAME       = 3'd2,
    END_DRAW   = 3'd3,
    END_WAIT   = 3'd4
  } state_t;

  // True in the states where the full-screen fill engine owns the VGA port.
  function automatic logic is_draw(input state_t s);
    return (s == TITLE_DRAW) || (s == END_DRAW);
  endfunction

endpackage

// File: rtl/screen_sequencer_rr_arbiter.sv
// Round-robin arbiter with burst lock for the gameplay VGA write port.
//
// Handshake: req[i] is a level held by requester i for its whole burst;
// grant is registered, one-hot or zero, and changes on the edge after req
// changes. A pixel from requester i is accepted on every edge where
// grant[i] and req[i] are both 1. Dropping enable clears grant on that edge.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]      last_holder;
  logic [IW-1:0]      next_holder;
  logic [NUM_REQ-1:0] next_grant;
  int                 cand;

  // Hold the current holder while it still requests; otherwise search
  // from last_holder+1 with wrap, so the last holder has lowest priority.
  always_comb begin
    next_grant  = '0;
    next_holder = last_holder;
    cand        = 0;
    if (enable) begin
      if ((grant & req) != '0) begin
        next_grant = grant;
      end else begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          cand = int'(last_holder) + k;
          if (cand >= NUM_REQ) cand = cand - NUM_REQ;
          if ((next_grant == '0) && req[cand[IW-1:0]]) begin
            next_grant[cand[IW-1:0]] = 1'b1;
            next_holder              = cand[IW-1:0];
          end
        end
      end
    end
  end

  // Grant and last-holder registers; after reset requester 0 wins first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant       <= '0;
      last_holder <= IW'(NUM_REQ - 1);
    end else begin
      grant       <= next_grant;
      last_holder <= next_holder;
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Game screen sequencer: title fill, gameplay sprite arbitration, end fill,
// with a registered VGA write-port mux between fill engine and requesters.
module screen_sequencer
  import screen_sequencer_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start_key,
  input  logic                   game_over,
  input  logic                   fill_done,
  input  logic [X_W-1:0]         fill_x,
  input  logic [Y_W-1:0]         fill_y,
  input  logic [C_W-1:0]         fill_colour,
  output logic                   fill_plot,
  output logic                   display_title,
  output logic                   display_end,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [X_W*NUM_REQ-1:0] req_x,
  input  logic [Y_W*NUM_REQ-1:0] req_y,
  input  logic [C_W*NUM_REQ-1:0] req_colour,
  output logic [NUM_REQ-1:0]     grant,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [C_W-1:0]         vga_colour,
  output logic                   vga_plot,
  output logic [2:0]             state
);

  state_t         state_q;
  state_t         state_d;
  logic           fill_plot_c;
  logic           title_c;
  logic           end_c;
  logic           arb_enable;
  logic           sel_hit;
  logic [X_W-1:0] sel_x;
  logic [Y_W-1:0] sel_y;
  logic [C_W-1:0] sel_colour;

  assign state = state_q;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= TITLE_DRAW;
    else         state_q <= state_d;
  end

  // Next-state and fill-engine control decode.
  always_comb begin
    state_d     = state_q;
    fill_plot_c = 1'b0;
    title_c     = 1'b0;
    end_c       = 1'b0;
    case (state_q)
      TITLE_DRAW: begin
        fill_plot_c = 1'b1;
        title_c     = 1'b1;
        if (fill_done) state_d = TITLE_WAIT;
      end
      TITLE_WAIT: if (start_key) state_d = GAME;
      GAME:       if (game_over) state_d = END_DRAW;
      END_DRAW: begin
        fill_plot_c = 1'b1;
        end_c       = 1'b1;
        if (fill_done) state_d = END_WAIT;
      end
      END_WAIT:   if (start_key) state_d = TITLE_DRAW;
      default:    state_d = TITLE_DRAW;
    endcase
  end

  // Fill controls stay low while reset is held, even though the state is
  // already TITLE_DRAW.
  assign fill_plot     = fill_plot_c & resetn;
  assign display_title = title_c & resetn;
  assign display_end   = end_c & resetn;

  // Leaving GAME on game_over clears grant on the same edge.
  assign arb_enable = (state_q == GAME) && !game_over;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .enable (arb_enable),
    .grant  (grant)
  );

  // Pick the granted requester's pixel slice.
  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    sel_hit    = |(grant & req);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_x      = req_x[i*X_W +: X_W];
        sel_y      = req_y[i*Y_W +: Y_W];
        sel_colour = req_colour[i*C_W +: C_W];
      end
    end
  end

  // Registered VGA write port. In DRAW states the plot strobe is fill_plot
  // delayed one cycle, suppressed on the exit edge so WAIT never writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else if (is_draw(state_q)) begin
      vga_x      <= fill_x;
      vga_y      <= fill_y;
      vga_colour <= fill_colour;
      vga_plot   <= fill_plot_c & ~fill_done;
    end else if (state_q == GAME) begin
      vga_x      <= sel_x;
      vga_y      <= sel_y;
      vga_colour <= sel_colour;
      vga_plot   <= sel_hit & ~game_over;
    end else begin
      vga_plot   <= 1'b0;
    end
  end

endmodule
